// File: rtl/vram_arbiter.sv
// Tile-map VRAM port arbiter: display reads own every visible pixel slot,
// while the clear-screen engine and the host writer share the remaining cycles.
module vram_arbiter #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 60,
  parameter int unsigned DW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pixel_tick,
  input  logic          video_on,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          wr_req,
  input  logic [12:0]   wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [12:0]   ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] rgb
);

  localparam int unsigned AW        = 13;
  localparam int unsigned NUM_TILES = ROWS * COLS;
  localparam logic [AW-1:0] LAST_TILE = AW'(NUM_TILES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [DW-1:0] clr_color_q, clr_color_d;
  logic          clr_last_q, clr_last_d;

  logic [AW-1:0] ram_addr_d;
  logic          ram_we_d;
  logic [DW-1:0] ram_wdata_d;
  logic          wr_ack_d;
  logic          clr_busy_d;

  logic          disp_slot_c;
  logic [6:0]    tile_row_c;
  logic [6:0]    tile_col_c;
  logic [AW-1:0] disp_addr_c;
  logic          wr_in_range_c;

  logic [1:0]    tick_pipe_q;
  logic [1:0]    von_pipe_q;

  logic          unused_lsbs;
  assign unused_lsbs = ^{pixel_x[2:0], pixel_y[2:0]};

  // Tile index for an 80-column map: row*64 + row*16 + col.
  assign disp_slot_c   = pixel_tick & video_on;
  assign tile_row_c    = pixel_y[9:3];
  assign tile_col_c    = pixel_x[9:3];
  assign disp_addr_c   = (AW'(tile_row_c) << 6) + (AW'(tile_row_c) << 4) + AW'(tile_col_c);
  assign wr_in_range_c = (wr_addr < AW'(NUM_TILES));

  // Port decision for this cycle; everything lands on the RAM pins next cycle.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    clr_last_d  = 1'b0;
    ram_addr_d  = ram_addr;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata;
    wr_ack_d    = 1'b0;

    if (disp_slot_c) begin
      ram_addr_d = disp_addr_c;
    end

    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d     = CLEAR;
          clr_color_d = clr_color;
          clr_cnt_d   = '0;
        end else if (!disp_slot_c && wr_req && !wr_ack) begin
          // A write already on the pins blocks a re-grant of the same held request.
          ram_addr_d  = wr_addr;
          ram_wdata_d = wr_data;
          ram_we_d    = wr_in_range_c;
          wr_ack_d    = 1'b1;
        end
      end
      CLEAR: begin
        if (!disp_slot_c) begin
          ram_addr_d  = clr_cnt_q;
          ram_wdata_d = clr_color_q;
          ram_we_d    = 1'b1;
          if (clr_cnt_q == LAST_TILE) begin
            state_d    = IDLE;
            clr_cnt_d  = '0;
            clr_last_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    clr_busy_d = (state_d == CLEAR) || clr_last_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
      clr_last_q  <= 1'b0;
      ram_addr    <= '0;
      ram_we      <= 1'b0;
      ram_wdata   <= '0;
      wr_ack      <= 1'b0;
      clr_busy    <= 1'b0;
      clr_done    <= 1'b0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
      clr_last_q  <= clr_last_d;
      ram_addr    <= ram_addr_d;
      ram_we      <= ram_we_d;
      ram_wdata   <= ram_wdata_d;
      wr_ack      <= wr_ack_d;
      clr_busy    <= clr_busy_d;
      clr_done    <= clr_last_q;
    end
  end

  // Read data returns two cycles after the tick; blank forces black.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_pipe_q <= '0;
      von_pipe_q  <= '0;
      rgb         <= '0;
    end else begin
      tick_pipe_q <= {tick_pipe_q[0], pixel_tick};
      von_pipe_q  <= {von_pipe_q[0], video_on};
      if (!von_pipe_q[1]) begin
        rgb <= '0;
      end else if (tick_pipe_q[1]) begin
        rgb <= ram_rdata;
      end
    end
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter COLS, default 80, tiles per row (8x8-pixel tiles).
REQ-002 Parameter ROWS, default 60, tile rows per frame.
REQ-003 Parameter DW, default 8, colour word width (RRRGGGBB).
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pixel_tick  in  1  one-clk strobe per pixel from the sync generator (1 of every 4 clk).
REQ-007 video_on  in  1  visible-area flag from the sync generator.
REQ-008 pixel_x, pixel_y  in  10 each  current pixel position.
REQ-009 wr_req  in  1; wr_addr  in  13; wr_data  in  DW: writer request, held until wr_ack.
REQ-010 wr_ack  out  1  one-clk grant pulse per accepted write.
REQ-011 clr_start  in  1; clr_color  in  DW: clear-screen command and fill colour.
REQ-012 clr_busy  out  1  clear in progress; clr_done  out  1  one-clk pulse at clear end.
REQ-013 ram_addr  out  13; ram_we  out  1; ram_wdata  out  DW; ram_rdata  in  DW: single-port sync RAM, read latency 1 clk.
REQ-014 rgb  out  DW  pixel colour to the DAC.

Function
REQ-015 Display slot = cycle with pixel_tick=1 and video_on=1; display SHALL own the RAM port in every display slot, no exceptions.
REQ-016 Display address = (pixel_y>>3)*COLS + (pixel_x>>3), shift-add only (row*64+row*16+col), 13 bits.
REQ-017 All ram_* outputs registered: request decided in cycle T drives ram_* in T+1.
REQ-018 Display tick at T: ram_addr at T+1 (ram_we=0), ram_rdata at T+2, rgb registered at T+3.
REQ-019 rgb SHALL be 0 at T+3 when video_on at T was 0 (video_on pipelined 3 stages); rgb otherwise holds between updates.
REQ-020 FSM states IDLE, CLEAR; IDLE->CLEAR on clr_start; CLEAR->IDLE after last address written.
REQ-021 CLEAR: each non-display cycle writes clr_color (latched at clr_start) to clr counter address, counter +1; counter 0..ROWS*COLS-1 (4799).
REQ-022 clr_busy=1 from cycle after clr_start until cycle of last write; clr_done pulses the cycle after last write drives ram_we.
REQ-023 clr_start while in CLEAR SHALL be ignored (no restart, colour unchanged).
REQ-024 IDLE, non-display cycle, wr_req=1: write granted; ram_we/ram_addr/ram_wdata driven next cycle with wr_ack=1 in that same cycle.
REQ-025 Writer holds wr_req/addr/data until wr_ack; wr_req still high the cycle after wr_ack counts as a new request.
REQ-026 At most one request per cycle; a granted write blocks further decisions until its ram cycle completes (no double grant).
REQ-027 wr_addr >= 4800: acknowledged normally, ram_we forced 0 (write dropped).
REQ-028 clr_start and wr_req same IDLE cycle: clear wins; write granted only after CLEAR->IDLE.
REQ-029 wr_req during CLEAR: no wr_ack until clear completes.
REQ-030 Non-display, no-grant cycles: ram_we=0, ram_addr holds last value.

Reset
REQ-031 reset=1 at a clk edge: state IDLE, clr counter 0, all outputs (ram_addr, ram_we, ram_wdata, rgb, wr_ack, clr_busy, clr_done) 0, video_on pipeline cleared.
REQ-032 reset mid-clear aborts; no clr_done pulse; RAM contents not restored.
REQ-033 reset mid-write: pending grant cancelled, no wr_ack issued.

Verification
REQ-034 Tick at T with video_on=1, pixel_x=17, pixel_y=9 -> ram_addr=82, ram_we=0 at T+1; ram_rdata=0xE0 at T+2 -> rgb=0xE0 at T+3.
REQ-035 wr_req, addr=100, data=0x1C coincident with display slot -> no grant that cycle; granted next free cycle; ram_we=1 ram_addr=100 ram_wdata=0x1C with wr_ack=1 exactly once.
REQ-036 clr_start, clr_color=0x03, ticks every 4 clk with video_on=1 -> 4800 writes of 0x03 to addresses 0..4799 once each, interleaved reads never skipped, single clr_done pulse, clr_busy low afterward.
REQ-037 clr_start and wr_req (addr=5) same cycle -> no wr_ack while clr_busy=1; write to 5 occurs after clear, final RAM[5]=wr_data.
REQ-038 wr_addr=4800 -> wr_ack pulses, ram_we stays 0.
REQ-039 reset asserted at clear address 2000 -> all outputs 0 next cycle, no clr_done, state IDLE; video_on=0 tick -> rgb=0 at T+3.
